// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, address map and lane helpers for the lsu_mc load/store unit.
//   lsu_op_e    - RISC-V funct3 load/store size codes
//   lsu_state_e - request FSM states
//   io_sel_e    - decoded I/O register select
//   *_BASE      - word addresses of the memory-mapped I/O registers
//   HEX_BLANK   - 7-segment pattern with every segment off
package lsu_pkg;

   typedef enum logic [2:0] {
      LSU_B  = 3'b000,
      LSU_H  = 3'b001,
      LSU_W  = 3'b010,
      LSU_BU = 3'b100,
      LSU_HU = 3'b101
   } lsu_op_e;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} lsu_state_e;

   typedef enum logic [2:0] {
      IO_NONE, IO_LEDR, IO_LEDG, IO_HEX_LO, IO_HEX_HI, IO_LCD, IO_SW, IO_BTN
   } io_sel_e;

   localparam logic [15:0] LEDR_BASE   = 16'h7000;
   localparam logic [15:0] LEDG_BASE   = 16'h7010;
   localparam logic [15:0] HEX_LO_BASE = 16'h7020;
   localparam logic [15:0] HEX_HI_BASE = 16'h7024;
   localparam logic [15:0] LCD_BASE    = 16'h7030;
   localparam logic [15:0] SW_BASE     = 16'h7800;
   localparam logic [15:0] BTN_BASE    = 16'h7810;

   localparam logic [6:0] HEX_BLANK = 7'h7F;

   function automatic logic op_legal(input logic [2:0] op);
      return op inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU};
   endfunction

   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
      case (op)
         LSU_H, LSU_HU: return off[0];
         LSU_W:         return off != 2'b00;
         default:       return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] byte_mask(input logic [2:0] op, input logic [1:0] off);
      case (op)
         LSU_B, LSU_BU: return 4'b0001 << off;
         LSU_H, LSU_HU: return 4'b0011 << off;
         LSU_W:         return 4'b1111;
         default:       return 4'b0000;
      endcase
   endfunction

   // Right-aligned store data moved up to the lane addressed by off.
   function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] data);
      case (op)
         LSU_B, LSU_BU: return {24'h0, data[7:0]} << {off, 3'b000};
         LSU_H, LSU_HU: return {16'h0, data[15:0]} << {off, 3'b000};
         default:       return data;
      endcase
   endfunction

   // Pick the addressed lane out of a word, then sign- or zero-extend it.
   function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] word);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (op)
         LSU_B:   return {{24{sh[7]}}, sh[7:0]};
         LSU_H:   return {{16{sh[15]}}, sh[15:0]};
         LSU_W:   return sh;
         LSU_BU:  return {24'h0, sh[7:0]};
         LSU_HU:  return {16'h0, sh[15:0]};
         default: return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mc_if.sv
// lsu_mc_if: core <-> LSU request/response handshake.
//   req/ready           - request accepted when both high
//   lsu_wren/lsu_op     - store flag and funct3 size code
//   lsu_addr/st_data    - byte address and right-aligned store data
//   valid/ld_data/err   - one-cycle response strobe with extended load data and error flag
// master = core side, slave = LSU side.
interface lsu_mc_if #(parameter int ADDR_W = 16);
   logic              req;
   logic              ready;
   logic              lsu_wren;
   logic [2:0]        lsu_op;
   logic [ADDR_W-1:0] lsu_addr;
   logic [31:0]       st_data;
   logic              valid;
   logic [31:0]       ld_data;
   logic              err;

   modport master (output req, lsu_wren, lsu_op, lsu_addr, st_data,
                   input  ready, valid, ld_data, err);
   modport slave  (input  req, lsu_wren, lsu_op, lsu_addr, st_data,
                   output ready, valid, ld_data, err);
endinterface

// File: rtl/lsu_io_regs.sv
// lsu_io_regs: memory-mapped I/O block of lsu_mc.
//   i_clk, i_rst       - clock, asynchronous active-low reset
//   i_we, i_sel        - write strobe and decoded register select
//   i_bmask, i_wdata   - byte enables and lane-aligned write data
//   o_rdata            - raw 32-bit word of the selected register/input
//   i_io_sw, i_io_btn  - asynchronous switch/button inputs (synchronized here)
//   o_io_ledr/ledg/lcd - output registers; o_io_hex - 7-seg digits, digit k on [7k+6:7k]
module lsu_io_regs
   import lsu_pkg::*;
#(
   parameter int NUM_HEX     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_we,
   input  io_sel_e              i_sel,
   input  logic [3:0]           i_bmask,
   input  logic [31:0]          i_wdata,
   output logic [31:0]          o_rdata,
   input  logic [31:0]          i_io_sw,
   input  logic [3:0]           i_io_btn,
   output logic [31:0]          o_io_ledr,
   output logic [31:0]          o_io_ledg,
   output logic [31:0]          o_io_lcd,
   output logic [7*NUM_HEX-1:0] o_io_hex
);
   logic [31:0]                ledr_q, ledg_q, lcd_q;
   logic [NUM_HEX-1:0][6:0]    hex_q;
   logic [SYNC_STAGES-1:0][35:0] sync_q;   // {btn, sw} per stage
   logic [7:0][6:0]            hex_all;

   // NOTE: every clocked register is written with <= so all flops update from
   // pre-edge values; a blocking = here would make results depend on statement order.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         ledr_q <= '0;
         ledg_q <= '0;
         lcd_q  <= '0;
         hex_q  <= {NUM_HEX{HEX_BLANK}};
         sync_q <= '0;
      end else begin
         sync_q[0] <= {i_io_btn, i_io_sw};
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         if (i_we) begin
            for (int b = 0; b < 4; b++) begin
               if (i_bmask[b]) begin
                  if (i_sel == IO_LEDR) ledr_q[8*b +: 8] <= i_wdata[8*b +: 8];
                  if (i_sel == IO_LEDG) ledg_q[8*b +: 8] <= i_wdata[8*b +: 8];
                  if (i_sel == IO_LCD)  lcd_q[8*b +: 8]  <= i_wdata[8*b +: 8];
               end
            end
            // Byte k of a HEX word drives digit k (low word) or k+4 (high word).
            for (int k = 0; k < NUM_HEX; k++) begin
               if (i_bmask[k%4] && ((k < 4) ? (i_sel == IO_HEX_LO) : (i_sel == IO_HEX_HI)))
                  hex_q[k] <= i_wdata[8*(k%4) +: 7];
            end
         end
      end
   end

   // NOTE: combinational outputs get a default first so no path leaves them
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      hex_all = '0;
      for (int k = 0; k < NUM_HEX; k++) hex_all[k] = hex_q[k];
   end

   always_comb begin
      o_rdata = '0;
      case (i_sel)
         IO_LEDR:   o_rdata = ledr_q;
         IO_LEDG:   o_rdata = ledg_q;
         IO_LCD:    o_rdata = lcd_q;
         IO_HEX_LO: o_rdata = {1'b0, hex_all[3], 1'b0, hex_all[2], 1'b0, hex_all[1], 1'b0, hex_all[0]};
         IO_HEX_HI: o_rdata = {1'b0, hex_all[7], 1'b0, hex_all[6], 1'b0, hex_all[5], 1'b0, hex_all[4]};
         IO_SW:     o_rdata = sync_q[SYNC_STAGES-1][31:0];
         IO_BTN:    o_rdata = {28'h0, sync_q[SYNC_STAGES-1][35:32]};
         default:   o_rdata = '0;
      endcase
   end

   assign o_io_ledr = ledr_q;
   assign o_io_ledg = ledg_q;
   assign o_io_lcd  = lcd_q;
   assign o_io_hex  = hex_q;

endmodule

// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle load/store unit between the core and data SRAM / memory-mapped I/O.
//   i_clk, i_rst        - clock, asynchronous active-low reset
//   core (slave)        - request/response handshake from the memory stage
//   i_io_sw, i_io_btn   - switch/button inputs
//   o_io_*              - LED, LCD and 7-segment output registers
//   o_mem_*             - SRAM request (word address, lane data, byte mask, held strobes)
//   i_mem_rdata/ack     - SRAM read word and one-cycle completion pulse
// I/O and error requests answer one cycle after accept; DMEM requests wait for
// ack or TIMEOUT cycles.
module lsu_mc
   import lsu_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int NUM_HEX     = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   lsu_mc_if.slave              core,
   input  logic [31:0]          i_io_sw,
   input  logic [3:0]           i_io_btn,
   output logic [31:0]          o_io_ledr,
   output logic [31:0]          o_io_ledg,
   output logic [31:0]          o_io_lcd,
   output logic [7*NUM_HEX-1:0] o_io_hex,
   output logic [ADDR_W-1:0]    o_mem_addr,
   output logic [31:0]          o_mem_wdata,
   output logic [3:0]           o_mem_bmask,
   output logic                 o_mem_wren,
   output logic                 o_mem_rden,
   input  logic [31:0]          i_mem_rdata,
   input  logic                 i_mem_ack
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   lsu_state_e        state_q, state_d;
   logic              accept, is_dmem, req_err, io_we, timeout_hit;
   logic [1:0]        off;
   logic [ADDR_W-1:0] word_addr;
   io_sel_e           io_sel;
   logic [31:0]       io_rdata;

   logic              wren_q, err_q;
   logic [2:0]        op_q;
   logic [1:0]        off_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [3:0]        mask_q;
   logic [31:0]       wdata_q, resp_data_q;
   logic [CNT_W-1:0]  wait_cnt_q;

   // ---------------- request decode ----------------
   assign accept    = core.req && (state_q == IDLE);
   assign off       = core.lsu_addr[1:0];
   assign word_addr = {core.lsu_addr[ADDR_W-1:2], 2'b00};
   assign is_dmem   = (core.lsu_addr[ADDR_W-1:14] == '0);

   always_comb begin
      io_sel = IO_NONE;
      if      (word_addr == ADDR_W'(LEDR_BASE))   io_sel = IO_LEDR;
      else if (word_addr == ADDR_W'(LEDG_BASE))   io_sel = IO_LEDG;
      else if (word_addr == ADDR_W'(HEX_LO_BASE)) io_sel = IO_HEX_LO;
      else if (word_addr == ADDR_W'(HEX_HI_BASE)) io_sel = IO_HEX_HI;
      else if (word_addr == ADDR_W'(LCD_BASE))    io_sel = IO_LCD;
      else if (word_addr == ADDR_W'(SW_BASE))     io_sel = IO_SW;
      else if (word_addr == ADDR_W'(BTN_BASE))    io_sel = IO_BTN;
   end

   // Anything flagged here is answered with err and touches neither SRAM nor I/O.
   assign req_err = !op_legal(core.lsu_op) || misaligned(core.lsu_op, off)
                  || (!is_dmem && io_sel == IO_NONE)
                  || (core.lsu_wren && (io_sel == IO_SW || io_sel == IO_BTN));
   assign io_we   = accept && core.lsu_wren && !req_err && !is_dmem;

   assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = (!req_err && is_dmem) ? WAIT : RESP;
         WAIT: if (i_mem_ack || timeout_hit) state_d = RESP;
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath / response register ----------------
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wren_q      <= 1'b0;
         op_q        <= '0;
         off_q       <= '0;
         mem_addr_q  <= '0;
         mask_q      <= '0;
         wdata_q     <= '0;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         resp_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               err_q       <= req_err;
               resp_data_q <= (req_err || core.lsu_wren || is_dmem) ? 32'h0
                            : load_ext(core.lsu_op, off, io_rdata);
               wait_cnt_q  <= '0;
               if (!req_err && is_dmem) begin
                  wren_q     <= core.lsu_wren;
                  op_q       <= core.lsu_op;
                  off_q      <= off;
                  mem_addr_q <= word_addr;
                  mask_q     <= byte_mask(core.lsu_op, off);
                  wdata_q    <= store_lanes(core.lsu_op, off, core.st_data);
               end
            end
            WAIT: begin
               if (i_mem_ack) begin
                  resp_data_q <= wren_q ? 32'h0 : load_ext(op_q, off_q, i_mem_rdata);
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign core.ready   = (state_q == IDLE);
   assign core.valid   = (state_q == RESP);
   assign core.err     = (state_q == RESP) && err_q;
   assign core.ld_data = resp_data_q;

   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_mem_bmask = mask_q;
   assign o_mem_wren  = (state_q == WAIT) &&  wren_q;
   assign o_mem_rden  = (state_q == WAIT) && !wren_q;

   lsu_io_regs #(
      .NUM_HEX     (NUM_HEX),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_io (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_we      (io_we),
      .i_sel     (io_sel),
      .i_bmask   (byte_mask(core.lsu_op, off)),
      .i_wdata   (store_lanes(core.lsu_op, off, core.st_data)),
      .o_rdata   (io_rdata),
      .i_io_sw   (i_io_sw),
      .i_io_btn  (i_io_btn),
      .o_io_ledr (o_io_ledr),
      .o_io_ledg (o_io_ledg),
      .o_io_lcd  (o_io_lcd),
      .o_io_hex  (o_io_hex)
   );

endmodule
